// File: rtl/imem_loader_if.sv
// imem_loader_if: upstream byte stream plus instruction-memory write bus
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // loader side: consumes bytes, drives memory writes
    modport master (
        input  byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wdata
    );

    // environment side: produces bytes, observes memory writes
    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed big-endian word stream and writes it into
// instruction memory, then releases the CPU. Define IMEM_LOADER_CHECKSUM_EN to require
// a trailing mod-2^32 sum word before the load is accepted.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_run,
    output logic          load_done,
    output logic          load_error
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = CSUM;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t            state_q, state_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [23:0]       wbuf_q, wbuf_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif
    logic              ready;
    logic              fire;
    logic              word_done;
    logic [31:0]       word;

    // Handshake decode; DATA stops accepting once all N words have arrived
    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready = !start && (state_q == HDR || state_q == CSUM || (state_q == DATA && cnt_q != n_q));
`else
        ready = !start && (state_q == HDR || (state_q == DATA && cnt_q != n_q));
`endif
        fire      = bus.byte_valid && ready;
        word_done = fire && bcnt_q == 2'd3;
        word      = {wbuf_q, bus.byte_data};
    end

    // Next-state: byte packing, header decode, write strobes and completion
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        wbuf_d  = wbuf_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        if (start) begin
            state_d = HDR;
            bcnt_d  = '0;
            cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else begin
            if (fire) begin
                bcnt_d = bcnt_q + 2'd1;
                wbuf_d = word[23:0];
            end
            case (state_q)
                HDR: if (word_done) begin
                    n_d   = word[ADDR_W:0];
                    cnt_d = '0;
                    state_d = ({1'b0, word} > DEPTH) ? ERR : (word == '0) ? AFTER_DATA : DATA;
                end
                DATA: begin
                    if (word_done) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = word;
                        cnt_d   = cnt_q + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d   = sum_q + word;
`endif
                    end
                    if (we_q && cnt_q == n_q) state_d = AFTER_DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: if (word_done) state_d = (word == sum_q) ? DONE : ERR;
`endif
                default: ;
            endcase
        end
    end

    // State and datapath registers; reset abandons any load in progress
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            wbuf_q  <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            wbuf_q  <= wbuf_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    assign bus.byte_ready = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_run        = state_q == DONE;
    assign load_done      = state_q == DONE;
    assign load_error     = state_q == ERR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench; a load model queues expected writes, a monitor checks them
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_run, load_done, load_error;
    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .cpu_run(cpu_run), .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every write strobe must match the oldest outstanding expected write
    always @(negedge clk) begin
        wr_t w;
        if (reset && bus.imem_we) begin
            chk("we_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("we_addr", 32'(bus.imem_addr), 32'(w.addr));
                chk("we_data", bus.imem_wdata, w.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int gap;
        gap = $urandom_range(maxgap, 0);
        @(negedge clk);
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            @(negedge clk);
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.byte_ready) begin
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("ready_timeout", 32'(bus.byte_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        send_byte(w[31:24], maxgap);
        send_byte(w[23:16], maxgap);
        send_byte(w[15:8], maxgap);
        send_byte(w[7:0], maxgap);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'hA5;
        #1 chk("ready_during_start", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        bus.byte_valid = 1'b0;
        #1 chk("ready_in_hdr", 32'(bus.byte_ready), 32'd1);
        chk("status_cleared", 32'({load_done, load_error, cpu_run}), 32'd0);
    endtask

    task automatic wait_status(input logic ok);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (load_done || load_error) break;
        end
        chk("load_done", 32'(load_done), 32'(ok));
        chk("load_error", 32'(load_error), 32'(!ok));
        chk("cpu_run", 32'(cpu_run), 32'(ok));
        chk("ready_at_end", 32'(bus.byte_ready), 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    // reference load: header N, N words written to addresses 0..N-1, optional sum word
    task automatic load_words(input logic [31:0] ws[$], input logic [31:0] csum_delta, input int maxgap);
        logic [31:0] sum;
        logic        ok;
        sum = '0;
        ok  = (csum_delta == 0);
        do_start();
        send_word(32'(ws.size()), maxgap);
        foreach (ws[i]) begin
            exp_q.push_back({i[ADDR_W-1:0], ws[i]});
            sum += ws[i];
            send_word(ws[i], maxgap);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum + csum_delta, maxgap);
`endif
        idle();
        wait_status(ok);
    endtask

    task automatic oversize(input logic [31:0] n);
        do_start();
        send_word(n, 1);
        idle();
        wait_status(1'b0);
    endtask

    initial begin
        logic [31:0] ws[$];
        logic [31:0] w0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", 32'({bus.byte_ready, bus.imem_we, cpu_run, load_done, load_error}), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        reset = 1'b1;
        bus.byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ignores_valid", 32'(bus.byte_ready), 32'd0);
        bus.byte_valid = 1'b0;

        ws = {};
        ws.push_back(32'h20080005);
        ws.push_back(32'h8C090004);
        load_words(ws, 32'd0, 0);

        oversize(32'h00000101);
        oversize(32'h80000000);
        oversize(32'($urandom_range(32'hFFFF, DEPTH + 1)));

`ifdef IMEM_LOADER_CHECKSUM_EN
        ws = {};
        load_words(ws, 32'd0, 0);
        ws.push_back(32'h00000001);
        ws.push_back(32'hFFFFFFFF);
        load_words(ws, 32'd0, 0);
        load_words(ws, 32'd1, 0);
`else
        do_start();
        send_word(32'h0, 0);
        @(negedge clk);
        chk("zero_len_done_next_cycle", 32'(load_done), 32'd1);
        idle();
        wait_status(1'b1);
`endif

        do_start();
        send_word(32'd3, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        ws = {};
        ws.push_back(32'hCAFEF00D);
        load_words(ws, 32'd0, 0);

        ws = {};
        for (int i = 0; i < DEPTH; i++) ws.push_back($urandom);
        load_words(ws, 32'd0, 0);

        for (int k = 0; k < 10; k++) begin
            ws = {};
            for (int i = 0; i < int'($urandom_range(6, 1)); i++) ws.push_back($urandom);
            load_words(ws, 32'd0, 2);
        end

        do_start();
        send_word(32'd4, 0);
        w0 = $urandom;
        exp_q.push_back({{ADDR_W{1'b0}}, w0});
        send_word(w0, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        #3 reset = 1'b0;
        #1;
        chk("arst_outputs", 32'({bus.byte_ready, bus.imem_we, cpu_run, load_done, load_error}), 32'd0);
        chk("arst_addr", 32'(bus.imem_addr), 32'd0);
        chk("arst_wdata", bus.imem_wdata, 32'd0);
        chk("arst_writes_outstanding", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_idle_ready", 32'(bus.byte_ready), 32'd0);
        chk("post_rst_status", 32'({load_done, load_error, cpu_run}), 32'd0);
        bus.byte_valid = 1'b0;

        ws = {};
        ws.push_back($urandom);
        load_words(ws, 32'd0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width (depth 2**ADDR_W words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins or restarts a load.
REQ-005 SHALL have port byte_valid  input  1  upstream byte available.
REQ-006 SHALL have port byte_data  input  8  upstream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts byte this cycle.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port imem_addr  output  ADDR_W  word address of the write.
REQ-010 SHALL have port imem_wdata  output  32  instruction word written.
REQ-011 SHALL have port cpu_run  output  1  high releases the processor; low holds it in reset.
REQ-012 SHALL have port load_done  output  1  load completed successfully.
REQ-013 SHALL have port load_error  output  1  load aborted on a length or checksum fault.

Function
REQ-014 SHALL implement states IDLE, HDR, DATA, CSUM, DONE, ERR.
REQ-015 SHALL transfer a byte only when byte_valid && byte_ready are both high at a clock edge.
REQ-016 SHALL drive byte_ready high only in HDR, DATA or CSUM, and only when start is low.
REQ-017 SHALL assemble every 4 accepted bytes into one word, big-endian: the first byte goes to [31:24].
REQ-018 SHALL treat the first word after start (HDR) as the instruction count N.
REQ-019 SHALL go HDR->ERR when N > 2**ADDR_W.
REQ-020 SHALL go HDR->DONE when N == 0 (macro off), or HDR->CSUM (macro on).
REQ-021 SHALL otherwise go HDR->DATA with the address counter at 0.
REQ-022 SHALL, in DATA, pulse imem_we for exactly one cycle, in the cycle after each 4th-byte handshake, with imem_addr = counter and imem_wdata = the assembled word.
REQ-023 SHALL then increment the counter, continuing to accept bytes during the write cycle (one byte per clock sustained).
REQ-024 SHALL leave DATA after the Nth write strobe, to DONE (macro off) or to CSUM (macro on).
REQ-025 SHALL never wrap imem_addr: the maximum address written is N-1 <= 2**ADDR_W-1.
REQ-026 SHALL, in DONE, hold cpu_run=1 and load_done=1, with byte_ready=0.
REQ-027 SHALL, in ERR, hold load_error=1 and cpu_run=0, with byte_ready=0.
REQ-028 SHALL, on start in any state, go to HDR next cycle and clear the byte counter, word counter, load_done, load_error and cpu_run; a byte presented in the start cycle is not accepted.
REQ-029 SHALL, on an abort by start mid-word, discard the partial word and issue no imem_we for it.
REQ-030 SHALL ignore byte_valid in IDLE, DONE and ERR.

Reset
REQ-031 SHALL, while reset is low, asynchronously force state IDLE, all counters to 0, and imem_we, imem_addr, imem_wdata, byte_ready, cpu_run, load_done and load_error to 0.
REQ-032 SHALL, when reset asserts mid-load, abandon the load with no further imem_we; memory contents already written are undefined to the processor until the next load.

Configuration
REQ-033 SHALL support macro IMEM_LOADER_CHECKSUM_EN.
REQ-034 SHALL, when IMEM_LOADER_CHECKSUM_EN is defined, receive one extra 4-byte word in CSUM and compare it to the mod-2**32 sum of the N data words; a match goes to DONE, a mismatch goes to ERR.
REQ-035 SHALL, when IMEM_LOADER_CHECKSUM_EN is undefined, contain no CSUM logic and never enter CSUM.

Verification
REQ-036 SHALL cover basic load (macro off): start, then bytes 00 00 00 02, 20 08 00 05, 8C 09 00 04 -> imem_we at addr 0 with 0x20080005, then addr 1 with 0x8C090004; load_done=1 and cpu_run=1 after the second write.
REQ-037 SHALL cover oversize header: ADDR_W=8, header 0x00000101 -> ERR, load_error=1, byte_ready=0, no imem_we.
REQ-038 SHALL cover zero length: header 0x00000000 -> DONE the cycle after the 4th byte (macro off), no imem_we.
REQ-039 SHALL cover checksum (macro on): N=2 with words 0x00000001 and 0xFFFFFFFF, then checksum 0x00000000 -> DONE; the same load with checksum 0x00000001 -> ERR.
REQ-040 SHALL cover restart: start after 6 bytes of a 3-word load, then a fresh 1-word load -> exactly one imem_we total, at addr 0 with the new word.
REQ-041 SHALL cover async reset: reset low mid-DATA with byte_valid held high -> all outputs 0 immediately, state IDLE, no imem_we after release until a new start.
